// File: rtl/traffic_ctrl_gen2.sv
// Two-road traffic light controller with pedestrian walk phases,
// all-red clearance and a night flashing-yellow mode.
// Ports:
//   clk         : system clock
//   rst         : asynchronous reset, active-high
//   pedestrian  : host word, bit0 = walk request (rising edge),
//                 bit1 = flash enable (level)
//   led         : active-low {R1,Y1,G1,R2,Y2,G2,R3,G3}
//   state_o     : current state code
//   ped_pending : latched walk request not yet served
module traffic_ctrl_gen2 #(
    parameter int GREEN_CYC  = 100000000,
    parameter int YELLOW_CYC = 50000000,
    parameter int ALLRED_CYC = 10000000,
    parameter int WALK_CYC   = 100000000,
    parameter int FLASH_CYC  = 50000000,
    parameter int CNT_W      = 28
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pedestrian,
    output logic [7:0]  led,
    output logic [3:0]  state_o,
    output logic        ped_pending
);

    typedef enum logic [3:0] {
        S_G1    = 4'd1,
        S_Y1    = 4'd2,
        S_AR1   = 4'd3,
        S_G2    = 4'd4,
        S_Y2    = 4'd5,
        S_AR2   = 4'd6,
        S_PE1   = 4'd7,
        S_PE2   = 4'd8,
        S_FLASH = 4'd9
    } state_t;

    localparam logic [CNT_W-1:0] GREEN_L  = CNT_W'(GREEN_CYC - 1);
    localparam logic [CNT_W-1:0] YELLOW_L = CNT_W'(YELLOW_CYC - 1);
    localparam logic [CNT_W-1:0] ALLRED_L = CNT_W'(ALLRED_CYC - 1);
    localparam logic [CNT_W-1:0] WALK_L   = CNT_W'(WALK_CYC - 1);
    localparam logic [CNT_W-1:0] FLASH_L  = CNT_W'(FLASH_CYC - 1);

    state_t             state_q, state_d, succ;
    logic [CNT_W-1:0]   cnt_q, cnt_d, last_c;
    logic               blink_q, blink_d;
    logic               pend_q, pend_d;
    logic               ped_q;
    logic               flash_en, rise, expire, legal, enter_pe;
    logic [7:0]         lit;
    logic               unused_bits;

    assign flash_en    = pedestrian[1];
    assign rise        = pedestrian[0] & ~ped_q;
    assign unused_bits = ^pedestrian[31:2];

    // State register, phase counter, blink phase, request latch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_AR2;
            cnt_q   <= '0;
            blink_q <= 1'b1;
            pend_q  <= 1'b0;
            // Edge register starts high so a host that already
            // drives bit0 does not produce a request at release.
            ped_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            blink_q <= blink_d;
            pend_q  <= pend_d;
            ped_q   <= pedestrian[0];
        end
    end

    always_comb begin
        last_c = '0;
        case (state_q)
            S_G1, S_G2:   last_c = GREEN_L;
            S_Y1, S_Y2:   last_c = YELLOW_L;
            S_AR1, S_AR2: last_c = ALLRED_L;
            S_PE1, S_PE2: last_c = WALK_L;
            S_FLASH:      last_c = FLASH_L;
            default:      last_c = '0;
        endcase
    end

    assign expire = (cnt_q == last_c);
    assign legal  = (state_q >= S_G1) && (state_q <= S_FLASH);

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        blink_d = blink_q;
        succ    = S_AR2;
        case (state_q)
            S_G1:    succ = S_Y1;
            S_Y1:    succ = S_AR1;
            S_AR1:   succ = pend_q ? S_PE1 : S_G2;
            S_PE1:   succ = S_G2;
            S_G2:    succ = S_Y2;
            S_Y2:    succ = S_AR2;
            S_AR2:   succ = pend_q ? S_PE2 : S_G1;
            S_PE2:   succ = S_G1;
            default: succ = S_AR2;
        endcase
        if (!legal) begin
            state_d = S_AR2;
            cnt_d   = '0;
        end else if (state_q == S_FLASH) begin
            if (expire) begin
                cnt_d = '0;
                // Only leave after a dark half so the yellow
                // blink is never cut short.
                if (!blink_q && !flash_en) begin
                    state_d = S_AR2;
                end else begin
                    blink_d = ~blink_q;
                end
            end
        end else if (expire) begin
            cnt_d = '0;
            if (flash_en) begin
                state_d = S_FLASH;
                blink_d = 1'b1;
            end else begin
                state_d = succ;
            end
        end
    end

    // Entering a walk phase serves the request, but an edge
    // arriving on that very cycle is kept for the next round.
    assign enter_pe = ((state_d == S_PE1) || (state_d == S_PE2))
                      && (state_d != state_q);

    always_comb begin
        pend_d = pend_q | rise;
        if (enter_pe) begin
            pend_d = rise;
        end
    end

    // Output decode, active-high lamp pattern then inverted
    always_comb begin
        lit = 8'h92;
        case (state_q)
            S_G1:         lit = 8'h32;
            S_Y1:         lit = 8'h52;
            S_G2:         lit = 8'h86;
            S_Y2:         lit = 8'h8A;
            S_AR1, S_AR2: lit = 8'h92;
            S_PE1, S_PE2: lit = 8'h91;
            // Dark half keeps only the pedestrian red lit
            S_FLASH:      lit = blink_q ? 8'h4A : 8'h02;
            default:      lit = 8'h92;
        endcase
    end

    assign led         = ~lit;
    assign state_o     = state_q;
    assign ped_pending = pend_q;

endmodule

// File: tb/tb_traffic_ctrl_gen2.sv
// Scoreboard bench for traffic_ctrl_gen2 with short phase
// lengths and hand-computed per-cycle lamp sequences.
module tb_traffic_ctrl_gen2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] ped = '0;
    logic [7:0]  led;
    logic [3:0]  state_o;
    logic        ped_pending;

    traffic_ctrl_gen2 #(
        .GREEN_CYC  (8),
        .YELLOW_CYC (4),
        .ALLRED_CYC (2),
        .WALK_CYC   (6),
        .FLASH_CYC  (3),
        .CNT_W      (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pedestrian  (ped),
        .led         (led),
        .state_o     (state_o),
        .ped_pending (ped_pending)
    );

    initial forever #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] led;
        logic [3:0] st;
        logic       pend;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;
    event smp;

    // Expect n consecutive cycles showing the given outputs
    task automatic run(input logic [7:0] l, input logic [3:0] s,
                       input logic p, input int n);
        for (int i = 0; i < n; i++) begin
            q.push_back('{led: l, st: s, pend: p});
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_one();
        exp_t e;
        e = q.pop_front();
        vectors++;
        if (led !== e.led || state_o !== e.st || ped_pending !== e.pend) begin
            miscompares++;
            $display("FAIL vec%0d t=%0t: got led=%h st=%0d pend=%b, want led=%h st=%0d pend=%b",
                     vectors, $time, led, state_o, ped_pending,
                     e.led, e.st, e.pend);
        end
        if (!led[5] && !led[2]) begin
            miscompares++;
            $display("FAIL twogreen t=%0t: led=%h, want G1/G2 not both lit",
                     $time, led);
        end
        if (!led[0] && state_o != 4'd7 && state_o != 4'd8) begin
            miscompares++;
            $display("FAIL g3 t=%0t: led=%h st=%0d, want G3 dark outside PE",
                     $time, led, state_o);
        end
    endtask

    // Monitor: compares on every falling edge, or immediately when
    // the stimulus signals an off-edge sample.
    initial begin
        forever begin
            @(negedge clk or smp);
            if (q.size() > 0) check_one();
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        // Reset state
        run(8'h6D, 4'd6, 1'b0, 2);
        rst = 1'b0;

        // Free-running sequence
        run(8'h6D, 4'd6, 1'b0, 2);
        run(8'hCD, 4'd1, 1'b0, 8);
        run(8'hAD, 4'd2, 1'b0, 4);
        run(8'h6D, 4'd3, 1'b0, 2);
        run(8'h79, 4'd4, 1'b0, 8);
        run(8'h75, 4'd5, 1'b0, 4);
        run(8'h6D, 4'd6, 1'b0, 2);

        // Walk request during G1, served as PE1
        run(8'hCD, 4'd1, 1'b0, 2);
        ped[0] = 1'b1;
        run(8'hCD, 4'd1, 1'b0, 1);
        ped[0] = 1'b0;
        run(8'hCD, 4'd1, 1'b1, 5);
        run(8'hAD, 4'd2, 1'b1, 4);
        run(8'h6D, 4'd3, 1'b1, 2);
        run(8'h6E, 4'd7, 1'b0, 6);
        run(8'h79, 4'd4, 1'b0, 8);
        run(8'h75, 4'd5, 1'b0, 4);
        run(8'h6D, 4'd6, 1'b0, 2);
        run(8'hCD, 4'd1, 1'b0, 1);

        // Reset with bit0 already high: no walk phase
        rst = 1'b1;
        ped[0] = 1'b1;
        run(8'h6D, 4'd6, 1'b0, 1);
        rst = 1'b0;
        run(8'h6D, 4'd6, 1'b0, 2);
        run(8'hCD, 4'd1, 1'b0, 8);
        run(8'hAD, 4'd2, 1'b0, 4);
        run(8'h6D, 4'd3, 1'b0, 2);
        run(8'h79, 4'd4, 1'b0, 8);
        run(8'h75, 4'd5, 1'b0, 4);
        run(8'h6D, 4'd6, 1'b0, 2);

        // New request, then an edge on the PE1 entry cycle
        ped[0] = 1'b0;
        run(8'hCD, 4'd1, 1'b0, 1);
        ped[0] = 1'b1;
        run(8'hCD, 4'd1, 1'b0, 1);
        run(8'hCD, 4'd1, 1'b1, 6);
        run(8'hAD, 4'd2, 1'b1, 3);
        ped[0] = 1'b0;
        run(8'hAD, 4'd2, 1'b1, 1);
        run(8'h6D, 4'd3, 1'b1, 1);
        ped[0] = 1'b1;
        run(8'h6D, 4'd3, 1'b1, 1);
        run(8'h6E, 4'd7, 1'b1, 6);
        run(8'h79, 4'd4, 1'b1, 8);
        run(8'h75, 4'd5, 1'b1, 4);
        run(8'h6D, 4'd6, 1'b1, 2);
        run(8'h6E, 4'd8, 1'b0, 6);
        run(8'hCD, 4'd1, 1'b0, 8);
        run(8'hAD, 4'd2, 1'b0, 4);
        run(8'h6D, 4'd3, 1'b0, 2);

        // Flash enabled mid-G2, dropped during a lit half
        run(8'h79, 4'd4, 1'b0, 3);
        ped[1] = 1'b1;
        run(8'h79, 4'd4, 1'b0, 5);
        run(8'hB5, 4'd9, 1'b0, 3);
        run(8'hFD, 4'd9, 1'b0, 3);
        run(8'hB5, 4'd9, 1'b0, 1);
        ped[1] = 1'b0;
        run(8'hB5, 4'd9, 1'b0, 2);
        run(8'hFD, 4'd9, 1'b0, 3);
        run(8'h6D, 4'd6, 1'b0, 2);
        run(8'hCD, 4'd1, 1'b0, 1);

        // Pending request, then async reset mid-Y1
        ped[0] = 1'b0;
        run(8'hCD, 4'd1, 1'b0, 1);
        ped[0] = 1'b1;
        run(8'hCD, 4'd1, 1'b0, 1);
        run(8'hCD, 4'd1, 1'b1, 5);
        run(8'hAD, 4'd2, 1'b1, 2);
        #2;
        rst = 1'b1;
        #1;
        q.push_back('{led: 8'h6D, st: 4'd6, pend: 1'b0});
        -> smp;
        @(posedge clk);
        #1;
        run(8'h6D, 4'd6, 1'b0, 1);
        rst = 1'b0;
        ped[0] = 1'b0;
        run(8'h6D, 4'd6, 1'b0, 2);
        run(8'hCD, 4'd1, 1'b0, 2);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d vectors left, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
